// File: rtl/insert_03.sv
// Annex-B packer: turns 16-bit RBSP words into a start-coded, emulation-protected
// 16-bit byte stream through a small byte FIFO and a registered output stage.
module insert_03 #(
    parameter int FIFO_BYTES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] ai_data,
    input  logic        ai_we,
    input  logic        ai_sop,
    input  logic        ai_eop,
    input  logic        ai_half,
    output logic        ao_next,
    output logic [15:0] bo_data,
    output logic        bo_we,
    output logic        bo_last,
    output logic        bo_half,
    input  logic        bi_next,
    output logic [15:0] ep_count
);

    localparam int PTR_W    = (FIFO_BYTES > 1) ? $clog2(FIFO_BYTES) : 1;
    localparam int CNT_W    = $clog2(FIFO_BYTES + 1);
    localparam int MAX_PUSH = 7;

    function automatic logic [PTR_W-1:0] wrap(input int v);
        return PTR_W'(v % FIFO_BYTES);
    endfunction

    // accepted word waits one cycle here before the byte engine expands it
    logic        stg_valid;
    logic [15:0] stg_data;
    logic        stg_sop;
    logic        stg_eop;
    logic        stg_half;

    logic [1:0]       zc;
    logic             rdy;
    logic [CNT_W-1:0] occ;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       mem     [FIFO_BYTES];
    logic             mem_end [FIFO_BYTES];

    logic [7:0] eng_byte [8];
    logic       eng_end  [8];
    logic [2:0] eng_cnt;
    logic [1:0] eng_ep;
    logic [1:0] eng_zc;
    logic [7:0] cur_b;
    logic [7:0] last_b;
    logic [2:0] push_cnt;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            eng_byte[k] = 8'h00;
            eng_end[k]  = 1'b0;
        end
        eng_cnt = 3'd0;
        eng_ep  = 2'd0;
        eng_zc  = stg_sop ? 2'd0 : zc;
        cur_b   = 8'h00;
        last_b  = 8'h00;
        if (stg_sop) begin
            eng_byte[0] = 8'h00;
            eng_byte[1] = 8'h00;
            eng_byte[2] = 8'h00;
            eng_byte[3] = 8'h01;
            eng_cnt     = 3'd4;
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0 || !(stg_eop && stg_half)) begin
                cur_b = (i == 0) ? stg_data[15:8] : stg_data[7:0];
                if (eng_zc == 2'd2 && cur_b <= 8'h03) begin
                    eng_byte[eng_cnt] = 8'h03;
                    eng_cnt           = eng_cnt + 3'd1;
                    eng_ep            = eng_ep + 2'd1;
                    eng_zc            = 2'd0;
                end
                eng_byte[eng_cnt] = cur_b;
                eng_cnt           = eng_cnt + 3'd1;
                if (cur_b == 8'h00)
                    eng_zc = (eng_zc == 2'd2) ? 2'd2 : eng_zc + 2'd1;
                else
                    eng_zc = 2'd0;
                last_b = cur_b;
            end
        end
        if (stg_eop) begin
            if (last_b == 8'h00) begin
                eng_byte[eng_cnt] = 8'h03;
                eng_cnt           = eng_cnt + 3'd1;
                eng_ep            = eng_ep + 2'd1;
            end
            eng_end[eng_cnt - 3'd1] = 1'b1;
            eng_zc                  = 2'd0;
        end
    end

    assign push_cnt = stg_valid ? eng_cnt : 3'd0;

    // bytes still sitting in the stage count as committed, so space is always there for them
    logic [CNT_W:0] committed;
    assign committed = {1'b0, occ} + (CNT_W+1)'(push_cnt);
    assign ao_next   = rdy && (committed <= (CNT_W+1)'(FIFO_BYTES - MAX_PUSH));

    logic             load;
    logic [PTR_W-1:0] h0;
    logic [PTR_W-1:0] h1;
    logic [1:0]       pop_cnt;
    logic [15:0]      pop_data;
    logic             pop_last;
    logic             pop_half;

    assign load = !bo_we || bi_next;
    assign h0   = rd_ptr;
    assign h1   = wrap(int'(rd_ptr) + 1);

    // a NAL-end byte at the head always leaves alone, keeping the next NAL word-aligned
    always_comb begin
        pop_cnt  = 2'd0;
        pop_data = 16'h0000;
        pop_last = 1'b0;
        pop_half = 1'b0;
        if (load) begin
            if (occ >= CNT_W'(2) && !mem_end[h0]) begin
                pop_cnt  = 2'd2;
                pop_data = {mem[h0], mem[h1]};
                pop_last = mem_end[h1];
            end else if (occ != '0 && mem_end[h0]) begin
                pop_cnt  = 2'd1;
                pop_data = {mem[h0], 8'h00};
                pop_last = 1'b1;
                pop_half = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy       <= 1'b0;
            stg_valid <= 1'b0;
            stg_data  <= 16'h0000;
            stg_sop   <= 1'b0;
            stg_eop   <= 1'b0;
            stg_half  <= 1'b0;
            zc        <= 2'd0;
            ep_count  <= 16'h0000;
            occ       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bo_we     <= 1'b0;
            bo_data   <= 16'h0000;
            bo_last   <= 1'b0;
            bo_half   <= 1'b0;
        end else begin
            rdy       <= 1'b1;
            stg_valid <= ai_we && ao_next;
            if (ai_we && ao_next) begin
                stg_data <= ai_data;
                stg_sop  <= ai_sop;
                stg_eop  <= ai_eop;
                stg_half <= ai_half;
            end
            if (stg_valid) begin
                zc       <= eng_zc;
                ep_count <= (stg_sop ? 16'h0000 : ep_count) + 16'(eng_ep);
            end
            occ    <= occ + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
            wr_ptr <= wrap(int'(wr_ptr) + int'(push_cnt));
            rd_ptr <= wrap(int'(rd_ptr) + int'(pop_cnt));
            if (load) begin
                bo_we   <= (pop_cnt != 2'd0);
                bo_last <= pop_last;
                bo_half <= pop_half;
                if (pop_cnt != 2'd0)
                    bo_data <= pop_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_PUSH; k++) begin
            if (3'(k) < push_cnt) begin
                mem[wrap(int'(wr_ptr) + k)]     <= eng_byte[k];
                mem_end[wrap(int'(wr_ptr) + k)] <= eng_end[k];
            end
        end
    end

endmodule
